// File: rtl/arb64_rr_ctrl.sv
// Round-robin arbiter for 64 requesters that drives a one-hot grant through an h6to64 decoder.
// Optional hold-time watchdog enabled by defining ARB_TIMEOUT_EN.

module h6to64 (
    input  logic        En,
    input  logic [5:0]  w,
    output logic [63:0] y
);
    for (genvar gi = 0; gi < 64; gi++) begin : g_dec
        assign y[gi] = En && (w == 6'(gi));
    end
endmodule

module arb64_rr_ctrl #(
    parameter int HOLD_MAX = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [63:0] req,
    input  logic        done,
    output logic [5:0]  gnt_idx,
    output logic        gnt_en,
    output logic [63:0] gnt,
    output logic        busy,
    output logic        timeout
);
    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] GRANT = 1'b1;

    if (HOLD_MAX < 2 || HOLD_MAX > 255) begin : g_hold_range_bad
        $error("arb64_rr_ctrl: HOLD_MAX must be in 2..255");
    end

    logic [0:0]  state_reg, state_next;
    logic [5:0]  gnt_idx_reg, gnt_idx_next;
    logic        gnt_en_reg, gnt_en_next;
    logic [5:0]  last_reg, last_next;
    logic [5:0]  start;
    logic [63:0] rot;
    logic [5:0]  offset;
    logic [5:0]  winner;
    logic        release_hit;

`ifdef ARB_TIMEOUT_EN
    localparam logic [7:0] HOLD_LAST = 8'(HOLD_MAX - 1);
    logic [7:0] hcnt_reg, hcnt_next;
    logic       timeout_reg, timeout_next;
`endif

    // Rotate requests so bit 0 of rot is the requester just after the last winner.
    assign start = last_reg + 6'd1;
    for (genvar gi = 0; gi < 64; gi++) begin : g_rot
        assign rot[gi] = req[start + 6'(gi)];
    end

    always_comb begin
        offset = 6'd0;
        for (int i = 63; i >= 0; i--) begin
            if (rot[i]) begin
                offset = 6'(i);
            end
        end
    end

    assign winner      = start + offset;
    assign release_hit = done || !req[gnt_idx_reg];

    always_comb begin
        state_next   = state_reg;
        gnt_idx_next = gnt_idx_reg;
        gnt_en_next  = gnt_en_reg;
        last_next    = last_reg;
`ifdef ARB_TIMEOUT_EN
        hcnt_next    = hcnt_reg;
        timeout_next = 1'b0;
`endif
        case (state_reg)
            IDLE: begin
                if (|req) begin
                    gnt_idx_next = winner;
                    gnt_en_next  = 1'b1;
                    last_next    = winner;
                    state_next   = GRANT;
`ifdef ARB_TIMEOUT_EN
                    hcnt_next    = 8'd0;
`endif
                end else begin
                    gnt_en_next = 1'b0;
                end
            end
            GRANT: begin
                // A normal release takes precedence over a watchdog expiry.
                if (release_hit) begin
                    gnt_en_next = 1'b0;
                    state_next  = IDLE;
                end
`ifdef ARB_TIMEOUT_EN
                else if (hcnt_reg == HOLD_LAST) begin
                    gnt_en_next  = 1'b0;
                    timeout_next = 1'b1;
                    state_next   = IDLE;
                end else begin
                    hcnt_next = hcnt_reg + 8'd1;
                end
`endif
            end
            default: begin
                gnt_en_next = 1'b0;
                state_next  = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= IDLE;
            gnt_idx_reg <= 6'd0;
            gnt_en_reg  <= 1'b0;
            last_reg    <= 6'd63;
        end else begin
            state_reg   <= state_next;
            gnt_idx_reg <= gnt_idx_next;
            gnt_en_reg  <= gnt_en_next;
            last_reg    <= last_next;
        end
    end

`ifdef ARB_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            hcnt_reg    <= 8'd0;
            timeout_reg <= 1'b0;
        end else begin
            hcnt_reg    <= hcnt_next;
            timeout_reg <= timeout_next;
        end
    end
    assign timeout = timeout_reg;
`else
    assign timeout = 1'b0;
`endif

    h6to64 u_dec (
        .En (gnt_en_reg),
        .w  (gnt_idx_reg),
        .y  (gnt)
    );

    assign gnt_idx = gnt_idx_reg;
    assign gnt_en  = gnt_en_reg;
    assign busy    = gnt_en_reg;

endmodule
